if_fetch_stage: RTL

- IF stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with a single outstanding request. Receives responses on a valid-only channel.
- Presents each fetched instruction as an if_id_bus_t for IF/ID to latch.
- Obeys the hazard unit's stall and the EX-stage redirect (branch/jump). Discards stale responses so no wrong-path instruction reaches ID.

---
 rtl/if_fetch_stage_pkg.sv | 40 ++++
 rtl/if_fetch_stage_if.sv | 30 +++
 rtl/if_fetch_stage_pc_reg.sv | 42 ++++
 rtl/if_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage and the
// IF/ID pipeline register that consumes its output.
package if_fetch_stage_pkg;

    // addi x0, x0, 0: harmless filler when a fetch faults
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    // Sequential fetch stride (one 32-bit instruction word)
    localparam logic [31:0] PC_STEP = 32'h0000_0004;

    // Fetched instruction as presented to IF/ID
    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] inst;
    } if_id_bus_t;

    // Instruction trace record, valid exactly when if_id_bus_t.valid is
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } tracer_bus_t;

    // Faulting fetches never deliver memory data downstream
    function automatic logic [31:0] sel_inst(input logic [31:0] data,
                                             input logic        err,
                                             input logic [31:0] nop_inst);
        logic [31:0] res;
        if (err) begin
            res = nop_inst;
        end else begin
            res = data;
        end
        return res;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel, valid-only response
// channel. master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );

endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter of the fetch stage. Redirect beats sequential increment;
// redirect targets are forced word-aligned.
module if_fetch_stage_pc_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        incr_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: redirect target, sequential step (wraps mod 2^32) or hold
    always_comb begin
        pc_d = pc_q;
        if (redirect_en_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (incr_i) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with asynchronous reset to the boot address
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline. Keeps at most one fetch in flight,
// buffers a response that lands while IF/ID is stalled, and swallows the one
// stale response owed after a redirect so no wrong-path instruction reaches ID.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    stall_en,
    input  logic                    redirect_en,
    input  logic [31:0]             redirect_pc,
    if_fetch_stage_if.master        imem,
    output if_id_bus_t              if_id_bus
`ifdef TRACE
    ,
    output tracer_bus_t             tracer_bus
`endif
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  hold_inst_q;
    logic [31:0]  hold_inst_d;
    logic         hold_fault_q;
    logic         hold_fault_d;
    logic [31:0]  pc_s;
    logic [31:0]  pc_plus4_s;
    logic         req_valid_s;
    logic         consume_s;
    if_id_bus_t   bus_s;

    if_fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .redirect_en_i (redirect_en),
        .redirect_pc_i (redirect_pc),
        .incr_i        (consume_s),
        .pc_o          (pc_s)
    );

    assign pc_plus4_s = pc_s + PC_STEP;

    // Request channel: depends only on state and redirect, never on imem_rsp_*
    always_comb begin
        if (ARESETn && (state_q == REQ) && !redirect_en) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        imem.imem_req_valid = req_valid_s;
        if (ARESETn) begin
            imem.imem_req_addr = pc_s;
        end else begin
            imem.imem_req_addr = 32'h0000_0000;
        end
    end

    // IF/ID bus: live response in WAIT, buffered one in HOLD, zeros otherwise
    always_comb begin
        bus_s = {$bits(if_id_bus_t){1'b0}};
        case (state_q)
            WAIT: begin
                if (imem.imem_rsp_valid && !redirect_en) begin
                    bus_s.valid    = 1'b1;
                    bus_s.fault    = imem.imem_rsp_err;
                    bus_s.pc       = pc_s;
                    bus_s.pc_plus4 = pc_plus4_s;
                    bus_s.inst     = sel_inst(imem.imem_rsp_data, imem.imem_rsp_err, NOP_INST);
                end else begin
                    bus_s = {$bits(if_id_bus_t){1'b0}};
                end
            end
            HOLD: begin
                if (!redirect_en) begin
                    bus_s.valid    = 1'b1;
                    bus_s.fault    = hold_fault_q;
                    bus_s.pc       = pc_s;
                    bus_s.pc_plus4 = pc_plus4_s;
                    bus_s.inst     = hold_inst_q;
                end else begin
                    bus_s = {$bits(if_id_bus_t){1'b0}};
                end
            end
            default: begin
                bus_s = {$bits(if_id_bus_t){1'b0}};
            end
        endcase
        consume_s = bus_s.valid & ~stall_en;
    end

    // Next state: redirect first, then response/consume, then stall
    always_comb begin
        state_d      = state_q;
        hold_inst_d  = hold_inst_q;
        hold_fault_d = hold_fault_q;
        if (redirect_en) begin
            hold_inst_d  = 32'h0000_0000;
            hold_fault_d = 1'b0;
            case (state_q)
                REQ:     state_d = REQ;
                HOLD:    state_d = REQ;
                // A response still in flight must be swallowed later
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        state_d = REQ;
                    end else begin
                        state_d = DROP;
                    end
                end
                DROP:    state_d = DROP;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (req_valid_s && imem.imem_req_ready) begin
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (stall_en) begin
                            state_d      = HOLD;
                            hold_inst_d  = sel_inst(imem.imem_rsp_data, imem.imem_rsp_err, NOP_INST);
                            hold_fault_d = imem.imem_rsp_err;
                        end else begin
                            state_d = REQ;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
                HOLD: begin
                    if (stall_en) begin
                        state_d = HOLD;
                    end else begin
                        state_d      = REQ;
                        hold_inst_d  = 32'h0000_0000;
                        hold_fault_d = 1'b0;
                    end
                end
                DROP: begin
                    if (imem.imem_rsp_valid) begin
                        state_d = REQ;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // State and hold-buffer registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= REQ;
            hold_inst_q  <= 32'h0000_0000;
            hold_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_inst_q  <= hold_inst_d;
            hold_fault_q <= hold_fault_d;
        end
    end

    assign if_id_bus = bus_s;

`ifdef TRACE
    assign tracer_bus = '{valid: bus_s.valid, pc: bus_s.pc, inst: bus_s.inst};
`endif

endmodule
